// File: rtl/memory_pkg.sv
// rtl/memory_pkg.sv - shared types and byte-lane helpers for memory_be_init
package memory_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } init_state_e;

  // Widest word / lane count the lane-merge helper supports.
  localparam int MAX_DW = 256;
  localparam int MAX_NB = 256;

  // Number of byte lanes in a word.
  function automatic int num_bytes(input int datawidth, input int bytewidth);
    return datawidth / bytewidth;
  endfunction

  // Parameter sanity rule checked at elaboration by the top level.
  function automatic bit cfg_ok(input int datawidth, input int bytewidth,
                                input int addrwidth, input int memsize);
    return (bytewidth > 0) && (datawidth % bytewidth == 0) &&
           (datawidth <= MAX_DW) && (datawidth / bytewidth <= MAX_NB) &&
           (memsize >= 1) && (memsize <= (1 << addrwidth));
  endfunction

  // Lanes with be set take new_word, the rest keep old_word.
  function automatic logic [MAX_DW-1:0] lane_merge(input logic [MAX_DW-1:0] old_word,
                                                   input logic [MAX_DW-1:0] new_word,
                                                   input logic [MAX_NB-1:0] be,
                                                   input int bytewidth);
    logic [MAX_DW-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_DW; i++) begin
      mask[i] = be[8'(i / bytewidth)];
    end
    return (old_word & ~mask) | (new_word & mask);
  endfunction

endpackage

// File: rtl/memory_init_ctrl.sv
// rtl/memory_init_ctrl.sv - zero-fill sequencer: walks every address once after reset
module memory_init_ctrl
  import memory_pkg::*;
#(
  parameter int ADDRWIDTH = 4,
  parameter int MEMSIZE   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic                 init_we_o,
  output logic [ADDRWIDTH-1:0] init_addr_o,
  output logic                 init_done_o
);

  localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(MEMSIZE - 1);

  init_state_e          state_q, state_d;
  logic [ADDRWIDTH-1:0] cnt_q, cnt_d;

  // State and address counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // One zero write per edge in INIT; leave INIT on the edge that clears the last word.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_we_o   = 1'b0;
    init_addr_o = cnt_q;
    init_done_o = 1'b0;
    case (state_q)
      INIT: begin
        init_we_o = 1'b1;
        cnt_d     = cnt_q + ADDRWIDTH'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d = READY;
        end
      end
      READY: begin
        init_done_o = 1'b1;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

endmodule

// File: rtl/memory_be_init.sv
// rtl/memory_be_init.sv - dual-port byte-enable RAM with zero-fill init (optional MEMORY_BYPASS_EN)
module memory_be_init
  import memory_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int BYTEWIDTH = 8,
  parameter int ADDRWIDTH = 4,
  parameter int MEMSIZE   = 16,
  localparam int NUMBYTES = num_bytes(DATAWIDTH, BYTEWIDTH)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 WREN,
  input  logic [NUMBYTES-1:0]  WRBE,
  input  logic [ADDRWIDTH-1:0] WRADDR,
  input  logic [DATAWIDTH-1:0] WRDATA,
  input  logic                 RDEN,
  input  logic [ADDRWIDTH-1:0] RDADDR,
  output logic [DATAWIDTH-1:0] RDDATA,
  output logic                 RDVALID,
  output logic                 INITDONE
);

  if (!cfg_ok(DATAWIDTH, BYTEWIDTH, ADDRWIDTH, MEMSIZE)) begin : g_cfg_err
    $error("memory_be_init: illegal DATAWIDTH/BYTEWIDTH/ADDRWIDTH/MEMSIZE");
  end

  localparam logic [ADDRWIDTH:0] MEM_LIMIT = (ADDRWIDTH + 1)'(MEMSIZE);

  logic                 init_we;
  logic [ADDRWIDTH-1:0] init_addr;
  logic                 init_done;

  memory_init_ctrl #(
    .ADDRWIDTH (ADDRWIDTH),
    .MEMSIZE   (MEMSIZE)
  ) u_init_ctrl (
    .clk_i       (CLK),
    .rst_i       (RST),
    .init_we_o   (init_we),
    .init_addr_o (init_addr),
    .init_done_o (init_done)
  );

  assign INITDONE = init_done;

  logic [DATAWIDTH-1:0] mem_q [MEMSIZE];

  logic                 wr_in_range, rd_in_range, user_we;
  logic [DATAWIDTH-1:0] wr_old, wr_merged, rd_word;
  logic                 arr_we;
  logic [ADDRWIDTH-1:0] arr_addr;
  logic [DATAWIDTH-1:0] arr_wdata;
  logic [DATAWIDTH-1:0] rddata_q, rddata_d;
  logic                 rdvalid_q, rdvalid_d;

  assign wr_in_range = {1'b0, WRADDR} < MEM_LIMIT;
  assign rd_in_range = {1'b0, RDADDR} < MEM_LIMIT;
  assign user_we     = init_done && WREN && wr_in_range;

  // Partial writes are a read-modify-write of the addressed word.
  assign wr_old    = mem_q[WRADDR];
  assign wr_merged = DATAWIDTH'(lane_merge(MAX_DW'(wr_old), MAX_DW'(WRDATA),
                                           MAX_NB'(WRBE), BYTEWIDTH));

`ifdef MEMORY_BYPASS_EN
  // Write-first: a same-address write is forwarded lane by lane into the read.
  assign rd_word = (user_we && (WRADDR == RDADDR)) ? wr_merged : mem_q[RDADDR];
`else
  // Read-first: the read always sees the word as it was before this edge.
  assign rd_word = mem_q[RDADDR];
`endif

  // Array write port: the init sequencer owns it until INITDONE.
  always_comb begin
    arr_we    = 1'b0;
    arr_addr  = WRADDR;
    arr_wdata = wr_merged;
    if (init_we) begin
      arr_we    = 1'b1;
      arr_addr  = init_addr;
      arr_wdata = '0;
    end else if (user_we) begin
      arr_we = 1'b1;
    end
  end

  // Storage array, deliberately not reset; the init sequencer clears it.
  always_ff @(posedge CLK) begin
    if (arr_we) begin
      mem_q[arr_addr] <= arr_wdata;
    end
  end

  // Read port next state: out-of-range reads still pulse valid but return zero.
  always_comb begin
    rdvalid_d = 1'b0;
    rddata_d  = rddata_q;
    if (init_done && RDEN) begin
      rdvalid_d = 1'b1;
      rddata_d  = rd_in_range ? rd_word : '0;
    end
  end

  // Registered read data and valid pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rddata_q  <= '0;
      rdvalid_q <= 1'b0;
    end else begin
      rddata_q  <= rddata_d;
      rdvalid_q <= rdvalid_d;
    end
  end

  assign RDDATA  = rddata_q;
  assign RDVALID = rdvalid_q;

endmodule
